alu_multibyte_seq: RTL and testbench

Multi-byte operation sequencer sitting directly upstream of the 8-bit ALU, with its result path wrapped back to collect the ALU output. It accepts one NBYTES-wide request and issues it to the ALU as NBYTES byte operations, chaining carry and borrow from byte to byte. It then assembles the wide result and returns it on a valid/ready response port.

---
 rtl/alu_multibyte_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_multibyte_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multibyte_seq.sv
// Sequences one NBYTES-wide request through the 8-bit ALU byte by byte, chaining carry/borrow.
// Optional wide-result flags (rsp_zero, rsp_neg) are built when MB_SEQ_FLAGS_EN is defined.
module alu_multibyte_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic                  req_cin,
    output logic [4:0]            alu_opcode,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_enable,
    output logic                  alu_input_ready,
    output logic                  alu_carry_in,
    output logic                  alu_borrow_in,
    input  logic [7:0]            alu_result,
    input  logic                  alu_carry_out,
    input  logic                  alu_borrow_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_result,
    output logic                  rsp_carry
`ifdef MB_SEQ_FLAGS_EN
    ,
    output logic                  rsp_zero,
    output logic                  rsp_neg
`endif
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [IW-1:0]   idx;
    logic [W-1:0]    result_q;
    logic [W-1:0]    result_next;
    logic [IW-1:0]   first_idx;
    logic [IW-1:0]   next_idx;
    logic            last_byte;

    function automatic logic [4:0] alu_code(input logic [2:0] op);
        case (op)
            3'd0:    alu_code = 5'd1;
            3'd1:    alu_code = 5'd3;
            3'd2:    alu_code = 5'd8;
            3'd3:    alu_code = 5'd9;
            3'd4:    alu_code = 5'd10;
            3'd5:    alu_code = 5'd11;
            3'd6:    alu_code = 5'd18;
            default: alu_code = 5'd19;
        endcase
    endfunction

    function automatic logic [7:0] lane(input logic [W-1:0] w, input logic [IW-1:0] i);
        lane = w[{i, 3'b000} +: 8];
    endfunction

    function automatic logic uses_carry(input logic [2:0] op);
        uses_carry = (op == OP_ADD) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic uses_b(input logic [2:0] op);
        uses_b = (op <= 3'd4);
    endfunction

    assign alu_input_ready = alu_enable;
    assign rsp_result      = result_q;

    // SHR walks from the top byte down so the shifted-in bit enters at the MSB.
    always_comb begin
        first_idx   = (req_op == OP_SHR) ? LAST_IDX : '0;
        last_byte   = (op_q == OP_SHR) ? (idx == '0) : (idx == LAST_IDX);
        next_idx    = (op_q == OP_SHR) ? idx - 1'b1 : idx + 1'b1;
        result_next = result_q;
        result_next[{idx, 3'b000} +: 8] = alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            idx           <= '0;
            result_q      <= '0;
            rsp_valid     <= 1'b0;
            rsp_carry     <= 1'b0;
            alu_opcode    <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_enable    <= 1'b0;
            alu_carry_in  <= 1'b0;
            alu_borrow_in <= 1'b0;
`ifdef MB_SEQ_FLAGS_EN
            rsp_zero      <= 1'b0;
            rsp_neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q          <= req_op;
                        a_q           <= req_a;
                        b_q           <= req_b;
                        idx           <= first_idx;
                        req_ready     <= 1'b0;
                        state         <= ISSUE;
                        alu_opcode    <= alu_code(req_op);
                        alu_a         <= lane(req_a, first_idx);
                        alu_b         <= uses_b(req_op) ? lane(req_b, first_idx) : 8'h00;
                        alu_enable    <= 1'b1;
                        alu_carry_in  <= req_cin & uses_carry(req_op);
                        alu_borrow_in <= req_cin & (req_op == OP_SUB);
                    end
                end
                ISSUE: begin
                    alu_opcode    <= '0;
                    alu_a         <= '0;
                    alu_b         <= '0;
                    alu_enable    <= 1'b0;
                    alu_carry_in  <= 1'b0;
                    alu_borrow_in <= 1'b0;
                    state         <= CAPT;
                end
                CAPT: begin
                    // The ALU registered this byte at the edge that ended ISSUE.
                    result_q <= result_next;
                    if (last_byte) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        if (op_q == OP_SUB)
                            rsp_carry <= alu_borrow_out;
                        else
                            rsp_carry <= alu_carry_out & uses_carry(op_q);
`ifdef MB_SEQ_FLAGS_EN
                        rsp_zero  <= (result_next == '0);
                        rsp_neg   <= result_next[W-1];
`endif
                    end else begin
                        idx           <= next_idx;
                        state         <= ISSUE;
                        alu_opcode    <= alu_code(op_q);
                        alu_a         <= lane(a_q, next_idx);
                        alu_b         <= uses_b(op_q) ? lane(b_q, next_idx) : 8'h00;
                        alu_enable    <= 1'b1;
                        alu_carry_in  <= alu_carry_out & uses_carry(op_q);
                        alu_borrow_in <= alu_borrow_out & (op_q == OP_SUB);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Directed bench for alu_multibyte_seq with a behavioural 8-bit ALU (one-cycle latency).
module tb_alu_multibyte_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          req_cin;
    logic [4:0]    alu_opcode;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic          alu_enable;
    logic          alu_input_ready;
    logic          alu_carry_in;
    logic          alu_borrow_in;
    logic [7:0]    alu_result;
    logic          alu_carry_out;
    logic          alu_borrow_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_carry;
    logic          rsp_zero;
    logic          rsp_neg;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] got_result;
    logic         got_carry;
    logic         got_zero;
    logic         got_neg;
    int           got_lat;
    logic [7:0]   issue_q[$];
    logic         cin_q[$];

    alu_multibyte_seq #(.NBYTES(NB)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_cin         (req_cin),
        .alu_opcode      (alu_opcode),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_enable      (alu_enable),
        .alu_input_ready (alu_input_ready),
        .alu_carry_in    (alu_carry_in),
        .alu_borrow_in   (alu_borrow_in),
        .alu_result      (alu_result),
        .alu_carry_out   (alu_carry_out),
        .alu_borrow_out  (alu_borrow_out),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
`ifdef MB_SEQ_FLAGS_EN
        .rsp_carry       (rsp_carry),
        .rsp_zero        (rsp_zero),
        .rsp_neg         (rsp_neg)
`else
        .rsp_carry       (rsp_carry)
`endif
    );

`ifndef MB_SEQ_FLAGS_EN
    assign rsp_zero = 1'b0;
    assign rsp_neg  = 1'b0;
`endif

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- 8-bit ALU model: registers on enable; logic ops leave the flags untouched ----
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result     <= '0;
            alu_carry_out  <= 1'b0;
            alu_borrow_out <= 1'b0;
        end else if (alu_enable) begin
            case (alu_opcode)
                5'd1: begin
                    {alu_carry_out, alu_result} <= 9'(alu_a) + 9'(alu_b) + 9'(alu_carry_in);
                    alu_borrow_out <= 1'b0;
                end
                5'd3: begin
                    alu_result     <= alu_a - alu_b - 8'(alu_borrow_in);
                    alu_borrow_out <= (9'(alu_a) < (9'(alu_b) + 9'(alu_borrow_in)));
                    alu_carry_out  <= 1'b0;
                end
                5'd8:  alu_result <= alu_a & alu_b;
                5'd9:  alu_result <= alu_a | alu_b;
                5'd10: alu_result <= alu_a ^ alu_b;
                5'd11: alu_result <= ~alu_a;
                5'd18: begin
                    alu_result    <= {alu_a[6:0], alu_carry_in};
                    alu_carry_out <= alu_a[7];
                end
                5'd19: begin
                    alu_result    <= {alu_carry_in, alu_a[7:1]};
                    alu_carry_out <= alu_a[0];
                end
                default: alu_result <= 8'hEE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst && alu_enable) begin
            issue_q.push_back(alu_a);
            cin_q.push_back(alu_carry_in);
        end
    end

    // ---- driver tasks ----
    task automatic send_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin);
        int guard;
        guard     = 0;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_valid = 1'b1;
        while (!req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_req_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic get_rsp();
        got_lat = 0;
        while (!rsp_valid && got_lat < 100) begin
            @(posedge clk); #1;
            got_lat++;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        got_result = rsp_result;
        got_carry  = rsp_carry;
        got_zero   = rsp_zero;
        got_neg    = rsp_neg;
        @(posedge clk); #1;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_rsp_carry: got %b expected 0", rsp_carry); end
        checks++; if ({alu_enable, alu_input_ready, alu_carry_in, alu_borrow_in} !== 4'b0)
            begin errors++; $display("FAIL reset_alu_strobes: got %b expected 0000",
                {alu_enable, alu_input_ready, alu_carry_in, alu_borrow_in}); end
        checks++; if ({alu_opcode, alu_a, alu_b} !== 21'h0)
            begin errors++; $display("FAIL reset_alu_bus: got %h expected 0", {alu_opcode, alu_a, alu_b}); end
`ifdef MB_SEQ_FLAGS_EN
        checks++; if ({rsp_zero, rsp_neg} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {rsp_zero, rsp_neg}); end
`endif
    endtask

    task automatic test_add();
        issue_q.delete();
        cin_q.delete();
        send_req(3'd0, 32'h01020304, 32'h10203040, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h11223344) begin errors++; $display("FAIL add_result: got %h expected 11223344", got_result); end
        checks++; if (got_carry !== 1'b0) begin errors++; $display("FAIL add_carry: got %b expected 0", got_carry); end
        checks++; if (got_lat !== 8) begin errors++; $display("FAIL add_latency: got %0d expected 8", got_lat); end
        checks++; if (issue_q.size() !== 4) begin errors++; $display("FAIL add_issue_count: got %0d expected 4", issue_q.size()); end
        checks++; if (issue_q.size() == 4 && issue_q[0] !== 8'h04) begin errors++; $display("FAIL add_lsb_first: got %h expected 04", issue_q[0]); end
    endtask

    task automatic test_add_carry();
        cin_q.delete();
        send_req(3'd0, 32'h000000FF, 32'h00000001, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h00000100) begin errors++; $display("FAIL addc_result: got %h expected 00000100", got_result); end
        checks++; if (cin_q.size() < 2 || cin_q[1] !== 1'b1) begin errors++; $display("FAIL addc_chain_byte1: carry into byte1 missing, got %0d issues", cin_q.size()); end
        send_req(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h00000000) begin errors++; $display("FAIL addc_wrap_result: got %h expected 00000000", got_result); end
        checks++; if (got_carry !== 1'b1) begin errors++; $display("FAIL addc_wrap_carry: got %b expected 1", got_carry); end
        send_req(3'd0, 32'h00000000, 32'h00000000, 1'b1);
        get_rsp();
        checks++; if (got_result !== 32'h00000001) begin errors++; $display("FAIL addc_cin: got %h expected 00000001", got_result); end
    endtask

    task automatic test_sub();
        send_req(3'd1, 32'h00000100, 32'h00000001, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h000000FF) begin errors++; $display("FAIL sub_result: got %h expected 000000ff", got_result); end
        checks++; if (got_carry !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %b expected 0", got_carry); end
        send_req(3'd1, 32'h00000000, 32'h00000001, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_wrap_result: got %h expected ffffffff", got_result); end
        checks++; if (got_carry !== 1'b1) begin errors++; $display("FAIL sub_wrap_borrow: got %b expected 1", got_carry); end
        send_req(3'd1, 32'h00001000, 32'h00000000, 1'b1);
        get_rsp();
        checks++; if (got_result !== 32'h00000FFF) begin errors++; $display("FAIL sub_bin: got %h expected 00000fff", got_result); end
    endtask

    task automatic test_shifts();
        send_req(3'd6, 32'h80000001, 32'hFFFFFFFF, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h00000002) begin errors++; $display("FAIL shl_result: got %h expected 00000002", got_result); end
        checks++; if (got_carry !== 1'b1) begin errors++; $display("FAIL shl_carry: got %b expected 1", got_carry); end
        issue_q.delete();
        cin_q.delete();
        send_req(3'd7, 32'h80000001, 32'hFFFFFFFF, 1'b1);
        get_rsp();
        checks++; if (got_result !== 32'hC0000000) begin errors++; $display("FAIL shr_result: got %h expected c0000000", got_result); end
        checks++; if (got_carry !== 1'b1) begin errors++; $display("FAIL shr_carry: got %b expected 1", got_carry); end
        checks++; if (issue_q.size() !== 4 || issue_q[0] !== 8'h80 || issue_q[3] !== 8'h01)
            begin errors++; $display("FAIL shr_msb_first: issue order wrong, %0d issues", issue_q.size()); end
        checks++; if (cin_q.size() == 0 || cin_q[0] !== 1'b1) begin errors++; $display("FAIL shr_first_cin: first carry_in not 1"); end
    endtask

    task automatic test_logic();
        send_req(3'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h00000000) begin errors++; $display("FAIL xor_result: got %h expected 00000000", got_result); end
        checks++; if (got_carry !== 1'b0) begin errors++; $display("FAIL xor_carry: got %b expected 0", got_carry); end
`ifdef MB_SEQ_FLAGS_EN
        checks++; if ({got_zero, got_neg} !== 2'b10) begin errors++; $display("FAIL xor_flags: got %b expected 10", {got_zero, got_neg}); end
`endif
        send_req(3'd5, 32'h00000000, 32'h12345678, 1'b1);
        get_rsp();
        checks++; if (got_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL not_result: got %h expected ffffffff", got_result); end
`ifdef MB_SEQ_FLAGS_EN
        checks++; if ({got_zero, got_neg} !== 2'b01) begin errors++; $display("FAIL not_flags: got %b expected 01", {got_zero, got_neg}); end
`endif
        send_req(3'd2, 32'hF0F0FFFF, 32'h0FF0F00F, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h00F0F00F) begin errors++; $display("FAIL and_result: got %h expected 00f0f00f", got_result); end
        send_req(3'd3, 32'h12000034, 32'h00560000, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h12560034) begin errors++; $display("FAIL or_result: got %h expected 12560034", got_result); end
    endtask

    task automatic test_back_to_back();
        int guard;
        rsp_ready = 1'b0;
        send_req(3'd0, 32'h00000005, 32'h00000006, 1'b0);
        guard = 0;
        while (!rsp_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", rsp_valid); end
        req_op    = 3'd1;
        req_a     = 32'h0000000A;
        req_b     = 32'h00000003;
        req_cin   = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", rsp_valid); end
            checks++; if (rsp_result !== 32'h0000000B) begin errors++; $display("FAIL bp_hold_result: got %h expected 0000000b", rsp_result); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %b expected 0", req_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake_valid: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake_ready: got %b expected 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got %b expected 0", req_ready); end
        get_rsp();
        checks++; if (got_result !== 32'h00000007) begin errors++; $display("FAIL bp_second_result: got %h expected 00000007", got_result); end
        checks++; if (got_lat !== 8) begin errors++; $display("FAIL bp_second_latency: got %0d expected 8", got_lat); end
    endtask

    task automatic test_reset_mid();
        int seen;
        send_req(3'd0, 32'h44332211, 32'h01010101, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (alu_enable !== 1'b1 || alu_a !== 8'h33) begin errors++; $display("FAIL rm_byte2_issue: got en=%b a=%h expected en=1 a=33", alu_enable, alu_a); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_req_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL rm_rsp_result: got %h expected 0", rsp_result); end
        checks++; if ({alu_enable, alu_opcode, alu_a, alu_b} !== 22'h0) begin errors++; $display("FAIL rm_alu_bus: got %h expected 0", {alu_enable, alu_opcode, alu_a, alu_b}); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_response: got %0d valid cycles expected 0", seen); end
        send_req(3'd0, 32'h00000001, 32'h00000001, 1'b0);
        get_rsp();
        checks++; if (got_result !== 32'h00000002) begin errors++; $display("FAIL rm_next_add: got %h expected 00000002", got_result); end
        checks++; if (got_lat !== 8) begin errors++; $display("FAIL rm_next_latency: got %0d expected 8", got_lat); end
    endtask

    // ---- sequence and report ----
    initial begin
        test_reset();
        test_add();
        test_add_carry();
        test_sub();
        test_shifts();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
